// File: rtl/uart_pkg.sv
// ============================================================================
// uart_pkg : shared frame constants, receiver state encoding, parity helper.
// Revision : 1.0
// ============================================================================
`default_nettype none

package uart_pkg;

    localparam int   DATA_BITS = 8;
    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;

    typedef enum logic [2:0] {
        ST_ARM    = 3'd0,
        ST_IDLE   = 3'd1,
        ST_START  = 3'd2,
        ST_DATA   = 3'd3,
        ST_PARITY = 3'd4,
        ST_STOP   = 3'd5
    } rx_state_t;

    // Parity bit the transmitter appends so that data ^ parity has odd weight.
    function automatic logic odd_parity(input logic [DATA_BITS-1:0] i_byte);
        return ~^i_byte;
    endfunction

endpackage

`default_nettype wire

// File: rtl/uart_rx_sync.sv
// ============================================================================
// uart_rx_sync : two-flop synchroniser for the serial line, resets to idle (1).
// Revision     : 1.0
// ============================================================================
`default_nettype none

module uart_rx_sync (
    input  logic clock,
    input  logic reset,
    input  logic i_async,
    output logic o_sync
);

    logic [1:0] r_meta;

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_meta <= 2'b11;
        end else begin
            r_meta <= {r_meta[0], i_async};
        end
    end

    assign o_sync = r_meta[1];

endmodule

`default_nettype wire

// File: rtl/uart_frame_receiver.sv
// ============================================================================
// uart_frame_receiver : oversampling 8-O-1 UART receiver with a one-deep
//                       valid/ack holding register.
// Revision            : 1.0
// ============================================================================
`default_nettype none

module uart_frame_receiver
    import uart_pkg::*;
#(
    parameter int OVERSAMPLE = 16
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 rxd,
    input  logic                 data_ack,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 data_valid,
    output logic                 parity_error,
    output logic                 framing_error,
    output logic                 overrun
);

    localparam int                TICK_W    = $clog2(OVERSAMPLE);
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(OVERSAMPLE - 1);
    localparam logic [TICK_W-1:0] TICK_MID  = TICK_W'(OVERSAMPLE / 2 - 1);
    localparam logic [2:0]        BIT_LAST  = 3'(DATA_BITS - 1);

    logic                 w_rs;
    logic                 w_tick_last;
    logic                 w_tick_mid;
    rx_state_t            r_state;
    logic [TICK_W-1:0]    r_tick;
    logic [2:0]           r_bit_idx;
    logic [DATA_BITS-1:0] r_shift;
    logic                 r_par;

    uart_rx_sync u_sync (
        .clock   (clock),
        .reset   (reset),
        .i_async (rxd),
        .o_sync  (w_rs)
    );

    assign w_tick_last = (r_tick == TICK_LAST);
    assign w_tick_mid  = (r_tick == TICK_MID);

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state       <= ST_ARM;
            r_tick        <= '0;
            r_bit_idx     <= '0;
            r_shift       <= '0;
            r_par         <= 1'b0;
            data_out      <= '0;
            data_valid    <= 1'b0;
            parity_error  <= 1'b0;
            framing_error <= 1'b0;
            overrun       <= 1'b0;
        end else begin
            framing_error <= 1'b0;
            overrun       <= 1'b0;
            if (data_valid && data_ack) begin
                data_valid <= 1'b0;
            end

            case (r_state)
                // Wait for a full bit period of idle line before trusting a start edge.
                ST_ARM: begin
                    if (w_rs != STOP_BIT) begin
                        r_tick <= '0;
                    end else if (w_tick_last) begin
                        r_tick  <= '0;
                        r_state <= ST_IDLE;
                    end else begin
                        r_tick <= r_tick + 1'b1;
                    end
                end
                ST_IDLE: begin
                    if (w_rs == START_BIT) begin
                        r_tick  <= '0;
                        r_state <= ST_START;
                    end
                end
                ST_START: begin
                    if (w_tick_mid) begin
                        r_tick <= '0;
                        if (w_rs == START_BIT) begin
                            r_bit_idx <= '0;
                            r_state   <= ST_DATA;
                        end else begin
                            r_state <= ST_IDLE;
                        end
                    end else begin
                        r_tick <= r_tick + 1'b1;
                    end
                end
                ST_DATA: begin
                    if (w_tick_last) begin
                        r_tick             <= '0;
                        r_shift[r_bit_idx] <= w_rs;
                        if (r_bit_idx == BIT_LAST) begin
                            r_state <= ST_PARITY;
                        end else begin
                            r_bit_idx <= r_bit_idx + 1'b1;
                        end
                    end else begin
                        r_tick <= r_tick + 1'b1;
                    end
                end
                ST_PARITY: begin
                    if (w_tick_last) begin
                        r_tick  <= '0;
                        r_par   <= w_rs;
                        r_state <= ST_STOP;
                    end else begin
                        r_tick <= r_tick + 1'b1;
                    end
                end
                ST_STOP: begin
                    if (w_tick_last) begin
                        r_tick <= '0;
                        if (w_rs == STOP_BIT) begin
                            r_state <= ST_IDLE;
                            // A same-cycle ack frees the holding register for the new byte.
                            if (!data_valid || data_ack) begin
                                data_out     <= r_shift;
                                parity_error <= (r_par != odd_parity(r_shift));
                                data_valid   <= 1'b1;
                            end else begin
                                overrun <= 1'b1;
                            end
                        end else begin
                            framing_error <= 1'b1;
                            r_state       <= ST_ARM;
                        end
                    end else begin
                        r_tick <= r_tick + 1'b1;
                    end
                end
                default: begin
                    r_tick  <= '0;
                    r_state <= ST_ARM;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_uart_frame_receiver.sv
// ============================================================================
// tb_uart_frame_receiver : directed, table-driven bench for uart_frame_receiver.
// Revision               : 1.0
// ============================================================================
`default_nettype none

module tb_uart_frame_receiver;

    localparam int OS = 16;
    // rxd driven after edge e0 reaches the FSM at edge e0+3 (T0); the stop
    // sample is at T0 + OS/2 + 10*OS, and data_valid is seen right after it.
    localparam int LOAD_OFS = 3 + OS / 2 + 10 * OS;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       rxd   = 1'b1;
    logic       data_ack = 1'b0;
    logic [7:0] data_out;
    logic       data_valid;
    logic       parity_error;
    logic       framing_error;
    logic       overrun;

    uart_frame_receiver #(.OVERSAMPLE(OS)) dut (
        .clock         (clock),
        .reset         (reset),
        .rxd           (rxd),
        .data_ack      (data_ack),
        .data_out      (data_out),
        .data_valid    (data_valid),
        .parity_error  (parity_error),
        .framing_error (framing_error),
        .overrun       (overrun)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int   rise_cyc   = -1;
    int   fall_cnt   = 0;
    int   fe_cnt     = 0;
    int   ov_cnt     = 0;
    logic prev_valid = 1'b0;
    always @(negedge clock) begin
        if (data_valid && !prev_valid) rise_cyc = cyc;
        if (!data_valid && prev_valid) fall_cnt = fall_cnt + 1;
        fe_cnt     = fe_cnt + int'(framing_error);
        ov_cnt     = ov_cnt + int'(overrun);
        prev_valid = data_valid;
    end

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic p, input logic s,
                              input bit ack_on_load, output int e0);
        logic [10:0] bits;
        bits = {s, p, d, 1'b0};
        e0   = cyc;
        for (int b = 0; b < 11; b++) begin
            rxd = bits[b];
            for (int k = 0; k < OS; k++) begin
                if (ack_on_load) data_ack = (cyc == e0 + LOAD_OFS - 1);
                @(posedge clock);
                #1;
            end
        end
        data_ack = 1'b0;
        rxd      = 1'b1;
    endtask

    task automatic ack_byte(input string name);
        data_ack = 1'b1;
        step(1);
        data_ack = 1'b0;
        chk(name, int'(data_valid), 0);
    endtask

    typedef struct {
        logic [7:0] d;
        logic       p;
        logic       s;
        logic       exp_valid;
        logic       exp_perr;
        int         exp_fe;
    } vec_t;

    vec_t vecs[5];
    int   e0;
    int   fe0;
    int   ov0;
    int   fall0;

    initial begin
        vecs[0] = '{d: 8'hA5, p: 1'b1, s: 1'b1, exp_valid: 1'b1, exp_perr: 1'b0, exp_fe: 0};
        vecs[1] = '{d: 8'h01, p: 1'b1, s: 1'b1, exp_valid: 1'b1, exp_perr: 1'b1, exp_fe: 0};
        vecs[2] = '{d: 8'h3C, p: 1'b1, s: 1'b0, exp_valid: 1'b0, exp_perr: 1'b0, exp_fe: 1};
        vecs[3] = '{d: 8'h00, p: 1'b1, s: 1'b1, exp_valid: 1'b1, exp_perr: 1'b0, exp_fe: 0};
        vecs[4] = '{d: 8'hC3, p: 1'b0, s: 1'b1, exp_valid: 1'b1, exp_perr: 1'b1, exp_fe: 0};

        step(3);
        chk("reset data_out", int'(data_out), 0);
        chk("reset data_valid", int'(data_valid), 0);
        chk("reset parity_error", int'(parity_error), 0);
        chk("reset framing_error", int'(framing_error), 0);
        chk("reset overrun", int'(overrun), 0);
        reset = 1'b1;
        step(20);

        data_ack = 1'b1;
        step(1);
        data_ack = 1'b0;
        chk("ack while empty", int'(data_valid), 0);

        foreach (vecs[i]) begin
            fe0 = fe_cnt;
            send_frame(vecs[i].d, vecs[i].p, vecs[i].s, 1'b0, e0);
            step(24);
            chk($sformatf("vec%0d valid", i), int'(data_valid), int'(vecs[i].exp_valid));
            chk($sformatf("vec%0d framing pulses", i), fe_cnt - fe0, vecs[i].exp_fe);
            if (vecs[i].exp_valid) begin
                chk($sformatf("vec%0d data", i), int'(data_out), int'(vecs[i].d));
                chk($sformatf("vec%0d parity_error", i), int'(parity_error), int'(vecs[i].exp_perr));
                chk($sformatf("vec%0d valid latency", i), rise_cyc, e0 + LOAD_OFS);
                ack_byte($sformatf("vec%0d valid after ack", i));
            end
        end

        // Overrun: second byte lands while the first is still held.
        ov0 = ov_cnt;
        send_frame(8'h11, 1'b1, 1'b1, 1'b0, e0);
        step(24);
        send_frame(8'h22, 1'b1, 1'b1, 1'b0, e0);
        step(24);
        chk("overrun pulses", ov_cnt - ov0, 1);
        chk("overrun keeps old byte", int'(data_out), 8'h11);
        chk("overrun keeps valid", int'(data_valid), 1);
        ack_byte("overrun valid after ack");

        // Ack coinciding with the load: new byte replaces old, valid never drops.
        ov0 = ov_cnt;
        send_frame(8'h11, 1'b1, 1'b1, 1'b0, e0);
        step(24);
        fall0 = fall_cnt;
        send_frame(8'h22, 1'b1, 1'b1, 1'b1, e0);
        step(24);
        chk("ack on load overrun", ov_cnt - ov0, 0);
        chk("ack on load data", int'(data_out), 8'h22);
        chk("ack on load valid", int'(data_valid), 1);
        chk("ack on load valid held", fall_cnt - fall0, 0);
        ack_byte("ack on load valid after ack");

        // Short low glitch is rejected as a false start.
        fe0 = fe_cnt;
        rxd = 1'b0;
        step(4);
        rxd = 1'b1;
        step(30);
        chk("glitch valid", int'(data_valid), 0);
        chk("glitch framing", fe_cnt - fe0, 0);
        send_frame(8'h7E, 1'b1, 1'b1, 1'b0, e0);
        step(24);
        chk("post-glitch data", int'(data_out), 8'h7E);
        chk("post-glitch parity_error", int'(parity_error), 0);
        chk("post-glitch latency", rise_cyc, e0 + LOAD_OFS);
        ack_byte("post-glitch valid after ack");

        // Line held low out of reset: receiver stays armed, reports nothing.
        reset = 1'b0;
        rxd   = 1'b0;
        step(2);
        reset = 1'b1;
        fe0   = fe_cnt;
        step(100);
        chk("stuck-low valid", int'(data_valid), 0);
        chk("stuck-low framing", fe_cnt - fe0, 0);

        // Reset mid-frame with a byte held: everything clears, partial byte lost.
        rxd = 1'b1;
        step(20);
        send_frame(8'h5A, 1'b1, 1'b1, 1'b0, e0);
        step(24);
        chk("pre-reset held data", int'(data_out), 8'h5A);
        rxd = 1'b0;
        step(OS);
        rxd = 1'b1;
        step(OS * 3);
        reset = 1'b0;
        step(1);
        chk("mid-frame reset data_out", int'(data_out), 0);
        chk("mid-frame reset valid", int'(data_valid), 0);
        chk("mid-frame reset parity_error", int'(parity_error), 0);
        step(1);
        reset = 1'b1;
        fe0   = fe_cnt;
        ov0   = ov_cnt;
        step(250);
        chk("after reset valid", int'(data_valid), 0);
        chk("after reset framing", fe_cnt - fe0, 0);
        chk("after reset overrun", ov_cnt - ov0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
